// File: rtl/sparc_pkg.sv
// ============================================================================
// Module   : sparc_pkg
// Purpose  : Shared encodings for the memory data register interface.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

package sparc_pkg;

    localparam logic [1:0] SZ_BYTE = 2'd0;
    localparam logic [1:0] SZ_HALF = 2'd1;
    localparam logic [1:0] SZ_WORD = 2'd2;

    localparam logic OP_RD = 1'b0;
    localparam logic OP_WR = 1'b1;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        WAIT_MOC = 2'd1,
        DONE     = 2'd2
    } state_t;

    // An access is legal when it fits in the word and is naturally aligned.
    function automatic logic access_legal(input logic [1:0] size,
                                          input int         addr,
                                          input int         max_size);
        if (int'(size) > max_size)
            return 1'b0;
        return ((addr & ((1 << size) - 1)) == 0);
    endfunction

endpackage

`default_nettype wire

// File: rtl/lane_align.sv
// ============================================================================
// Module   : lane_align
// Purpose  : Big-endian lane placement for stores and extraction/extension
//            for loads. Purely combinational.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module lane_align #(
    parameter  int DATA_W = 32,
    localparam int LANES  = DATA_W / 8,
    localparam int AW     = $clog2(LANES)
) (
    input  logic [1:0]        size_i,
    input  logic [AW-1:0]     addr_i,
    input  logic              sign_ext_i,
    input  logic [DATA_W-1:0] st_data_i,
    input  logic [DATA_W-1:0] ld_data_i,
    output logic [DATA_W-1:0] st_data_o,
    output logic [LANES-1:0]  byte_en_o,
    output logic [DATA_W-1:0] ld_data_o
);

    int                w_nbytes;
    int                w_shamt;
    logic [DATA_W-1:0] w_fmask;
    logic [LANES-1:0]  w_be_low;
    logic [DATA_W-1:0] w_ld_raw;
    logic              w_sbit;

    always_comb begin
        w_nbytes = 1 << size_i;
        if (w_nbytes > LANES)
            w_nbytes = LANES;
        // Offset 0 is the most significant lane, so the field sits this many
        // lanes above bit 0.
        w_shamt = LANES - int'(addr_i) - w_nbytes;
        if (w_shamt < 0)
            w_shamt = 0;

        w_fmask  = '0;
        w_be_low = '0;
        for (int b = 0; b < LANES; b++) begin
            if (b < w_nbytes) begin
                w_fmask[8*b +: 8] = 8'hFF;
                w_be_low[b]       = 1'b1;
            end
        end

        st_data_o = (st_data_i & w_fmask) << (8 * w_shamt);
        byte_en_o = w_be_low << w_shamt;

        w_ld_raw = (ld_data_i >> (8 * w_shamt)) & w_fmask;
        w_sbit   = 1'b0;
        for (int b = 0; b < LANES; b++) begin
            if (b == w_nbytes - 1)
                w_sbit = w_ld_raw[8*b + 7];
        end
        ld_data_o = (sign_ext_i && w_sbit) ? (w_ld_raw | ~w_fmask) : w_ld_raw;
    end

endmodule

`default_nettype wire

// File: rtl/mdr_mem_if.sv
// ============================================================================
// Module   : mdr_mem_if
// Purpose  : Memory data register with MFA/MOC handshake, timeout, and
//            lane-aligned store/load paths between the Ds bus and RAM.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module mdr_mem_if
    import sparc_pkg::*;
#(
    parameter  int DATA_W  = 32,
    parameter  int TIMEOUT = 15,
    localparam int LANES   = DATA_W / 8,
    localparam int AW      = $clog2(LANES)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [DATA_W-1:0] Ds,
    input  logic              MDRld,
    input  logic              start,
    input  logic              op,
    input  logic [1:0]        size,
    input  logic              sign_ext,
    input  logic [AW-1:0]     addr_lo,
    input  logic [DATA_W-1:0] mem_dout,
    input  logic              MOC,
    output logic              MFA,
    output logic [DATA_W-1:0] outToRAMIn,
    output logic [LANES-1:0]  byte_en,
    output logic [DATA_W-1:0] mdr_q,
    output logic              busy,
    output logic              done,
    output logic              err_align,
    output logic              err_timeout
);

    localparam int             CW       = $clog2(TIMEOUT) + 1;
    localparam logic [CW-1:0]  CNT_LAST = CW'(TIMEOUT - 1);

    state_t            state_q, state_d;
    logic [DATA_W-1:0] mdr_d;
    logic [DATA_W-1:0] out_q, out_d;
    logic [LANES-1:0]  be_q, be_d;
    logic              mfa_q, mfa_d;
    logic              done_q, done_d;
    logic              ea_q, ea_d;
    logic              et_q, et_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic              op_q, op_d;
    logic [1:0]        size_q, size_d;
    logic [AW-1:0]     addr_q, addr_d;
    logic              sx_q, sx_d;

    logic [1:0]        w_la_size;
    logic [AW-1:0]     w_la_addr;
    logic [DATA_W-1:0] w_st_data;
    logic [LANES-1:0]  w_st_be;
    logic [DATA_W-1:0] w_ld_data;
    logic              w_legal;

    // In IDLE the aligner sees the live request; afterwards the latched one.
    assign w_la_size = (state_q == IDLE) ? size    : size_q;
    assign w_la_addr = (state_q == IDLE) ? addr_lo : addr_q;
    assign w_legal   = access_legal(size, int'(addr_lo), AW);

    lane_align #(.DATA_W(DATA_W)) u_lane_align (
        .size_i     (w_la_size),
        .addr_i     (w_la_addr),
        .sign_ext_i (sx_q),
        .st_data_i  (Ds),
        .ld_data_i  (mem_dout),
        .st_data_o  (w_st_data),
        .byte_en_o  (w_st_be),
        .ld_data_o  (w_ld_data)
    );

    always_comb begin
        state_d = state_q;
        mdr_d   = mdr_q;
        out_d   = out_q;
        be_d    = be_q;
        mfa_d   = mfa_q;
        cnt_d   = cnt_q;
        op_d    = op_q;
        size_d  = size_q;
        addr_d  = addr_q;
        sx_d    = sx_q;
        done_d  = 1'b0;
        ea_d    = 1'b0;
        et_d    = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (start) begin
                    if (w_legal) begin
                        be_d    = w_st_be;
                        mfa_d   = 1'b1;
                        cnt_d   = '0;
                        op_d    = op;
                        size_d  = size;
                        addr_d  = addr_lo;
                        sx_d    = sign_ext;
                        state_d = WAIT_MOC;
                        if (op == OP_WR)
                            out_d = w_st_data;
                    end else begin
                        ea_d = 1'b1;
                    end
                end else if (MDRld) begin
                    mdr_d = Ds;
                end
            end
            WAIT_MOC: begin
                if (MOC) begin
                    if (op_q == OP_RD)
                        mdr_d = w_ld_data;
                    mfa_d   = 1'b0;
                    done_d  = 1'b1;
                    state_d = DONE;
                end else if (cnt_q == CNT_LAST) begin
                    mfa_d   = 1'b0;
                    be_d    = '0;
                    et_d    = 1'b1;
                    state_d = IDLE;
                end else if (cnt_q != '1) begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            DONE: begin
                if (!MOC) begin
                    be_d    = '0;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            mdr_q   <= '0;
            out_q   <= '0;
            be_q    <= '0;
            mfa_q   <= 1'b0;
            done_q  <= 1'b0;
            ea_q    <= 1'b0;
            et_q    <= 1'b0;
            cnt_q   <= '0;
            op_q    <= 1'b0;
            size_q  <= '0;
            addr_q  <= '0;
            sx_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            mdr_q   <= mdr_d;
            out_q   <= out_d;
            be_q    <= be_d;
            mfa_q   <= mfa_d;
            done_q  <= done_d;
            ea_q    <= ea_d;
            et_q    <= et_d;
            cnt_q   <= cnt_d;
            op_q    <= op_d;
            size_q  <= size_d;
            addr_q  <= addr_d;
            sx_q    <= sx_d;
        end
    end

    assign MFA         = mfa_q;
    assign outToRAMIn  = out_q;
    assign byte_en     = be_q;
    assign busy        = (state_q != IDLE);
    assign done        = done_q;
    assign err_align   = ea_q;
    assign err_timeout = et_q;

endmodule

`default_nettype wire

// File: tb/tb_mdr_mem_if.sv
// ============================================================================
// Module   : tb_mdr_mem_if
// Purpose  : Self-checking bench for mdr_mem_if (32-bit, TIMEOUT=15).
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_mdr_mem_if;

    localparam int DW    = 32;
    localparam int LANES = DW / 8;
    localparam int TO    = 15;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [DW-1:0] Ds;
    logic          MDRld, start, op, sign_ext, MOC;
    logic [1:0]    size;
    logic [1:0]    addr_lo;
    logic [DW-1:0] mem_dout;
    logic          MFA, busy, done, err_align, err_timeout;
    logic [DW-1:0] outToRAMIn, mdr_q;
    logic [LANES-1:0] byte_en;

    int n_vec = 0;
    int n_err = 0;

    mdr_mem_if #(.DATA_W(DW), .TIMEOUT(TO)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .Ds          (Ds),
        .MDRld       (MDRld),
        .start       (start),
        .op          (op),
        .size        (size),
        .sign_ext    (sign_ext),
        .addr_lo     (addr_lo),
        .mem_dout    (mem_dout),
        .MOC         (MOC),
        .MFA         (MFA),
        .outToRAMIn  (outToRAMIn),
        .byte_en     (byte_en),
        .mdr_q       (mdr_q),
        .busy        (busy),
        .done        (done),
        .err_align   (err_align),
        .err_timeout (err_timeout)
    );

    always #5 clk = ~clk;

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model (byte-array view of the word) ------
    function automatic logic [LANES-1:0] m_be(input int sz, input int a);
        logic [LANES-1:0] r = '0;
        int n = 1 << sz;
        for (int i = 0; i < LANES; i++)
            if (i >= a && i < a + n) r[LANES-1-i] = 1'b1;
        return r;
    endfunction

    function automatic logic [DW-1:0] m_store(input logic [DW-1:0] d, input int sz, input int a);
        logic [DW-1:0] r = '0;
        int n = 1 << sz;
        for (int j = 0; j < n; j++)
            r[DW-1-8*(a+j) -: 8] = d[8*(n-1-j) +: 8];
        return r;
    endfunction

    function automatic logic [DW-1:0] m_load(input logic [DW-1:0] m, input int sz, input int a, input logic sx);
        logic [DW-1:0] v = '0;
        int n = 1 << sz;
        for (int j = 0; j < n; j++)
            v = (v << 8) | DW'(m[DW-1-8*(a+j) -: 8]);
        if (sx && v[8*n-1])
            for (int k = 8*n; k < DW; k++) v[k] = 1'b1;
        return v;
    endfunction

    int               ph;       // 0 idle, 1 waiting for MOC, 2 completed
    int               waited;
    logic             l_op, l_sx;
    int               l_sz, l_a;
    logic             e_mfa, e_done, e_ea, e_et;
    logic [DW-1:0]    e_out, e_mdr;
    logic [LANES-1:0] e_be;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ph <= 0; waited <= 0; l_op <= 0; l_sx <= 0; l_sz <= 0; l_a <= 0;
            e_mfa <= 0; e_done <= 0; e_ea <= 0; e_et <= 0;
            e_out <= '0; e_mdr <= '0; e_be <= '0;
        end else begin
            e_done <= 1'b0;
            e_ea   <= 1'b0;
            e_et   <= 1'b0;
            case (ph)
                0: begin
                    if (start) begin
                        if ((1 << int'(size)) <= LANES && (int'(addr_lo) % (1 << int'(size))) == 0) begin
                            ph     <= 1;
                            waited <= 0;
                            e_mfa  <= 1'b1;
                            e_be   <= m_be(int'(size), int'(addr_lo));
                            l_op   <= op; l_sx <= sign_ext;
                            l_sz   <= int'(size); l_a <= int'(addr_lo);
                            if (op) e_out <= m_store(Ds, int'(size), int'(addr_lo));
                        end else begin
                            e_ea <= 1'b1;
                        end
                    end else if (MDRld) begin
                        e_mdr <= Ds;
                    end
                end
                1: begin
                    if (MOC) begin
                        if (!l_op) e_mdr <= m_load(mem_dout, l_sz, l_a, l_sx);
                        e_mfa  <= 1'b0;
                        e_done <= 1'b1;
                        ph     <= 2;
                    end else if (waited + 1 == TO) begin
                        e_mfa <= 1'b0;
                        e_be  <= '0;
                        e_et  <= 1'b1;
                        ph    <= 0;
                    end else begin
                        waited <= waited + 1;
                    end
                end
                default: begin
                    if (!MOC) begin
                        e_be <= '0;
                        ph   <= 0;
                    end
                end
            endcase
        end
    end

    always @(negedge clk) begin
        check("cyc_MFA",     64'(MFA),         64'(e_mfa));
        check("cyc_out",     64'(outToRAMIn),  64'(e_out));
        check("cyc_be",      64'(byte_en),     64'(e_be));
        check("cyc_mdr",     64'(mdr_q),       64'(e_mdr));
        check("cyc_busy",    64'(busy),        64'(ph != 0));
        check("cyc_done",    64'(done),        64'(e_done));
        check("cyc_ealign",  64'(err_align),   64'(e_ea));
        check("cyc_etime",   64'(err_timeout), 64'(e_et));
    end

    // ---------------- directed stimulus -------------------------------------
    logic [DW-1:0] exp_mdr;

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic issue(input logic o, input logic [1:0] sz, input logic [1:0] a,
                         input logic sx, input logic [DW-1:0] d);
        op = o; size = sz; addr_lo = a; sign_ext = sx; Ds = d; start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic rd(input logic [1:0] sz, input logic [1:0] a, input logic sx,
                      input logic [DW-1:0] mem, input logic [DW-1:0] exp, input string nm);
        issue(1'b0, sz, a, sx, 32'h0F0F0F0F);
        MOC = 1'b1; mem_dout = mem;
        tick();
        check(nm, 64'(mdr_q), 64'(exp));
        exp_mdr = exp;
        MOC = 1'b0;
        tick();
        tick();
    endtask

    task automatic wr(input logic [1:0] sz, input logic [1:0] a, input logic [DW-1:0] d,
                      input logic [DW-1:0] exp_out, input logic [LANES-1:0] exp_be, input string nm);
        issue(1'b1, sz, a, 1'b0, d);
        check({nm, "_out"}, 64'(outToRAMIn), 64'(exp_out));
        check({nm, "_be"},  64'(byte_en),    64'(exp_be));
        MOC = 1'b1;
        tick();
        MOC = 1'b0;
        tick();
        tick();
    endtask

    task automatic bad(input logic [1:0] sz, input logic [1:0] a, input string nm);
        MDRld = 1'b1;
        issue(1'b0, sz, a, 1'b0, 32'hBAD0BAD0);
        MDRld = 1'b0;
        check({nm, "_ea"},  64'(err_align), 64'd1);
        check({nm, "_mfa"}, 64'(MFA),       64'd0);
        tick();
        check({nm, "_ea_end"}, 64'(err_align), 64'd0);
        check({nm, "_mdr"},    64'(mdr_q),     64'(exp_mdr));
    endtask

    int mfa_cycles, to_seen;

    initial begin
        Ds = '0; MDRld = 0; start = 0; op = 0; size = 0; sign_ext = 0;
        addr_lo = 0; mem_dout = '0; MOC = 0; exp_mdr = '0;
        rst_n = 1'b1;
        #1 rst_n = 1'b0;
        tick(); tick();
        check("rst_mfa",  64'(MFA),        64'd0);
        check("rst_mdr",  64'(mdr_q),      64'd0);
        check("rst_out",  64'(outToRAMIn), 64'd0);
        check("rst_be",   64'(byte_en),    64'd0);
        check("rst_busy", 64'(busy),       64'd0);
        rst_n = 1'b1;
        tick();

        Ds = 32'hDEADBEEF; MDRld = 1'b1;
        tick();
        MDRld = 1'b0;
        check("mdrld_mdr", 64'(mdr_q), 64'hDEADBEEF);
        check("mdrld_mfa", 64'(MFA),   64'd0);
        exp_mdr = 32'hDEADBEEF;

        // byte write at offset 2, MOC three cycles after start
        issue(1'b1, 2'd0, 2'd2, 1'b0, 32'h000000AB);
        check("wb_out", 64'(outToRAMIn), 64'h0000AB00);
        check("wb_be",  64'(byte_en),    64'b0010);
        check("wb_mfa", 64'(MFA),        64'd1);
        tick(); tick();
        MOC = 1'b1;
        tick();
        check("wb_mfa_low", 64'(MFA),  64'd0);
        check("wb_done",    64'(done), 64'd1);
        MDRld = 1'b1; Ds = 32'h11111111;
        tick();
        MDRld = 1'b0;
        check("wb_done_end", 64'(done), 64'd0);
        check("wb_busy_dn",  64'(busy), 64'd1);
        MOC = 1'b0;
        tick();
        check("wb_idle", 64'(busy),    64'd0);
        check("wb_mdr",  64'(mdr_q),   64'hDEADBEEF);
        check("wb_be0",  64'(byte_en), 64'd0);

        rd(2'd1, 2'd0, 1'b1, 32'h9ABC5678, 32'hFFFF9ABC, "rd_half_s");
        rd(2'd1, 2'd0, 1'b0, 32'h9ABC5678, 32'h00009ABC, "rd_half_u");
        rd(2'd0, 2'd3, 1'b1, 32'h123456F0, 32'hFFFFFFF0, "rd_byte3_s");
        rd(2'd2, 2'd0, 1'b1, 32'h80000001, 32'h80000001, "rd_word");
        rd(2'd1, 2'd2, 1'b1, 32'h12347FFF, 32'h00007FFF, "rd_half2_pos");
        rd(2'd0, 2'd1, 1'b0, 32'hA1B2C3D4, 32'h000000B2, "rd_byte1_u");

        wr(2'd1, 2'd2, 32'hCAFE1234, 32'h00001234, 4'b0011, "wr_half2");
        wr(2'd2, 2'd0, 32'h01234567, 32'h01234567, 4'b1111, "wr_word");
        wr(2'd0, 2'd0, 32'h555555C3, 32'hC3000000, 4'b1000, "wr_byte0");

        bad(2'd2, 2'd1, "mis_word1");
        bad(2'd1, 2'd3, "mis_half3");
        bad(2'd3, 2'd0, "bad_size3");

        // timeout: MOC never arrives; start/MDRld/op changes mid-wait are ignored
        issue(1'b0, 2'd0, 2'd0, 1'b1, 32'h0);
        mfa_cycles = 0; to_seen = 0;
        for (int c = 0; c < 30; c++) begin
            if (MFA) mfa_cycles++;
            if (err_timeout) to_seen++;
            if (c >= 2 && c <= 4) begin
                start = 1'b1; MDRld = 1'b1; op = 1'b1; size = 2'd2; addr_lo = 2'd0;
                Ds = 32'h55555555;
            end else begin
                start = 1'b0; MDRld = 1'b0;
            end
            tick();
        end
        check("to_mfa_cycles", 64'(mfa_cycles), 64'd15);
        check("to_pulses",     64'(to_seen),    64'd1);
        check("to_mdr",        64'(mdr_q),      64'(exp_mdr));
        check("to_be",         64'(byte_en),    64'd0);

        // asynchronous reset in the middle of a transaction
        issue(1'b0, 2'd1, 2'd2, 1'b0, 32'h0);
        tick();
        check("ar_mfa_before", 64'(MFA), 64'd1);
        #2 rst_n = 1'b0;
        #1;
        check("ar_mfa",  64'(MFA),     64'd0);
        check("ar_busy", 64'(busy),    64'd0);
        check("ar_done", 64'(done),    64'd0);
        check("ar_mdr",  64'(mdr_q),   64'd0);
        check("ar_be",   64'(byte_en), 64'd0);
        tick(); tick();
        rst_n = 1'b1;
        tick();
        check("ar_done_after", 64'(done), 64'd0);

        rd(2'd0, 2'd2, 1'b1, 32'hA1B2C3D4, 32'hFFFFFFC3, "post_rst_rd");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule

`default_nettype wire
